// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable baud divisor
// and a frame state machine driving a registered, idle-high tx line.
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DEF_DIV    = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] r_data,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  FullCnt = 5'(FIFO_DEPTH);
  localparam logic [15:0] DefDiv  = 16'(DEF_DIV);

  localparam logic [1:0] RegTxData  = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegBaudDiv = 2'd2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q, count_d;
  logic            ovf_q;
  logic [15:0]     baud_div_q;
  logic [15:0]     div_q, cnt_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_idx_q;
  logic            tx_q, irq_q;

  logic [1:0] reg_sel;
  logic       wr_acc, rd_acc;
  logic       push_req, push_ok, pop;
  logic       fifo_full, fifo_empty, busy;
  logic       bit_done, idle_next, irq_d;
  logic [7:0] head;
  logic       unused_bits;

  assign reg_sel    = addr[3:2];
  assign wr_acc     = sel & wr_en;
  assign rd_acc     = sel & rd_en;
  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == 5'd0);
  assign busy       = (state_q != StIdle);
  assign push_req   = wr_acc && (reg_sel == RegTxData);
  assign push_ok    = push_req && !fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign bit_done   = (cnt_q == div_q - 16'd1);

  // A pop happens whenever the FSM is ready for a new frame: from IDLE, or on
  // the last cycle of a stop bit so frames run back to back.
  assign pop       = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
  assign idle_next = fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));
  assign count_d   = count_q + {4'd0, push_ok} - {4'd0, pop};
  assign irq_d     = idle_next && (count_d == 5'd0);

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

  // Storage is not reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      baud_div_q <= DefDiv;
    end else begin
      // A push into a full FIFO is dropped even if a pop frees a slot this edge.
      if (push_req && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr_acc && (reg_sel == RegStatus) && wdata[3]) begin
        ovf_q <= 1'b0;
      end
      if (wr_acc && (reg_sel == RegBaudDiv)) begin
        baud_div_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= DefDiv;
      cnt_q     <= 16'd0;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      irq_q <= irq_d;
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            div_q   <= baud_div_q;
            cnt_q   <= 16'd0;
            state_q <= StStart;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (bit_done) begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            state_q   <= StData;
            tx_q      <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StData: begin
          if (bit_done) begin
            cnt_q   <= 16'd0;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StStop: begin
          if (bit_done) begin
            cnt_q <= 16'd0;
            if (pop) begin
              shift_q <= head;
              div_q   <= baud_div_q;
              state_q <= StStart;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    r_data = 32'd0;
    if (rd_acc) begin
      case (reg_sel)
        RegStatus:  r_data = {23'd0, count_q, ovf_q, busy, fifo_empty, fifo_full};
        RegBaudDiv: r_data = {16'd0, baud_div_q};
        default:    r_data = 32'd0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, frame timing, back-to-back
// frames, overflow, divisor edge cases and asynchronous reset.
module tb_uart_tx_mmio;

  localparam logic [31:0] ATxData  = 32'h8000_0000;
  localparam logic [31:0] AStatus  = 32'h8000_0004;
  localparam logic [31:0] ABaudDiv = 32'h8000_0008;
  localparam logic [31:0] ARsvd    = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] r_data;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio #(
    .FIFO_DEPTH(8),
    .DEF_DIV   (434)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .addr  (addr),
    .wdata (wdata),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .r_data(r_data),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic s, input logic [31:0] a, input logic [31:0] d);
    sel   = s;
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    sel   = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    sel   = 1'b1;
    rd_en = 1'b1;
    addr  = a;
    #1;
    d     = r_data;
    sel   = 1'b0;
    rd_en = 1'b0;
  endtask

  // Entered just after the edge that started the frame's sample k0; returns just
  // after the edge that ends the frame. Bits before k0 were not observed here.
  task automatic frame(input logic [7:0] b, input int div, input int k0, input string tag);
    logic [9:0] pat;
    logic [9:0] obs;
    int glitch;
    int bi;
    pat    = {1'b1, b, 1'b0};
    obs    = pat;
    glitch = 0;
    for (int k = k0; k < 10 * div; k++) begin
      bi = k / div;
      if (k == k0 || (k % div) == 0) obs[bi] = tx;
      else if (tx !== obs[bi]) glitch++;
      tick();
    end
    check({tag, "_bits"}, 32'(obs), 32'(pat));
    check({tag, "_hold"}, 32'(glitch), 32'd0);
  endtask

  logic [31:0] rd;
  int          low_seen;

  initial begin
    // Reset and idle
    repeat (3) tick();
    check("rst_tx_during", 32'(tx), 32'd1);
    rst_n = 1'b1;
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    bus_rd(AStatus, rd);
    check("rst_status", rd, 32'h0000_0002);
    bus_rd(ABaudDiv, rd);
    check("rst_baud", rd, 32'd434);
    bus_rd(ARsvd, rd);
    check("rsvd_read", rd, 32'd0);
    bus_rd(ATxData, rd);
    check("txdata_read", rd, 32'd0);
    sel = 1'b1; addr = AStatus; #1;
    check("no_rd_en_zero", r_data, 32'd0);
    sel = 1'b0;
    bus_wr(1'b0, ATxData, 32'h55);
    bus_wr(1'b0, ABaudDiv, 32'd7);
    tick();
    bus_rd(AStatus, rd);
    check("unsel_status", rd, 32'h0000_0002);
    check("unsel_tx", 32'(tx), 32'd1);
    bus_rd(ABaudDiv, rd);
    check("unsel_baud", rd, 32'd434);

    // Single byte, 4 cycles per bit
    bus_wr(1'b1, ABaudDiv, 32'd4);
    bus_wr(1'b1, ATxData, 32'hA5);
    check("single_tx_pre", 32'(tx), 32'd1);
    tick();
    bus_rd(AStatus, rd);
    check("single_busy", rd, 32'h0000_0006);
    check("single_irq_low", 32'(irq), 32'd0);
    frame(8'hA5, 4, 0, "single");
    bus_rd(AStatus, rd);
    check("single_done_status", rd, 32'h0000_0002);
    check("single_done_irq", 32'(irq), 32'd1);

    // Back-to-back frames, no idle gap
    bus_wr(1'b1, ABaudDiv, 32'd2);
    bus_wr(1'b1, ATxData, 32'h00);
    bus_wr(1'b1, ATxData, 32'hFF);
    frame(8'h00, 2, 0, "b2b_first");
    check("b2b_irq_mid", 32'(irq), 32'd0);
    frame(8'hFF, 2, 0, "b2b_second");
    check("b2b_irq_end", 32'(irq), 32'd1);
    check("b2b_tx_end", 32'(tx), 32'd1);

    // Overflow: 10 pushes into an 8-deep FIFO with one immediate pop
    bus_wr(1'b1, ABaudDiv, 32'd100);
    for (int i = 1; i <= 10; i++) bus_wr(1'b1, ATxData, 32'(i));
    bus_rd(AStatus, rd);
    check("ovf_status", rd, 32'h0000_008D);
    bus_wr(1'b1, AStatus, 32'h8);
    bus_rd(AStatus, rd);
    check("ovf_cleared", rd, 32'h0000_0085);
    frame(8'h01, 100, 9, "ovf_b01");
    for (int i = 2; i <= 9; i++) frame(8'(i), 100, 0, $sformatf("ovf_b%02d", i));
    bus_rd(AStatus, rd);
    check("ovf_drained", rd, 32'h0000_0002);
    check("ovf_irq", 32'(irq), 32'd1);
    low_seen = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    check("ovf_no_tenth", 32'(low_seen), 32'd0);

    // Divisor 0 stores 1; mid-frame rewrite affects only the next frame
    bus_wr(1'b1, ABaudDiv, 32'd0);
    bus_rd(ABaudDiv, rd);
    check("div0_read", rd, 32'd1);
    bus_wr(1'b1, ATxData, 32'h3C);
    bus_wr(1'b1, ATxData, 32'h96);
    check("div1_start", 32'(tx), 32'd0);
    bus_wr(1'b1, ABaudDiv, 32'd8);
    frame(8'h3C, 1, 1, "div1_frame");
    frame(8'h96, 8, 0, "div8_frame");
    bus_rd(ABaudDiv, rd);
    check("div8_read", rd, 32'd8);

    // Asynchronous reset during data bit 3 with three bytes queued
    bus_wr(1'b1, ABaudDiv, 32'd4);
    bus_wr(1'b1, ATxData, 32'hF0);
    bus_wr(1'b1, ATxData, 32'h11);
    bus_wr(1'b1, ATxData, 32'h22);
    bus_wr(1'b1, ATxData, 32'h33);
    bus_rd(AStatus, rd);
    check("rstmid_queued", rd, 32'h0000_0034);
    repeat (15) tick();
    check("rstmid_bit3", 32'(tx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_async", 32'(tx), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bus_rd(AStatus, rd);
    check("rstmid_status", rd, 32'h0000_0002);
    bus_rd(ABaudDiv, rd);
    check("rstmid_baud", rd, 32'd434);
    low_seen = 0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1) low_seen++;
    end
    check("rstmid_no_frames", 32'(low_seen), 32'd0);
    check("rstmid_irq", 32'(irq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
